cakegame_multi: RTL
===================

Name: cakegame_multi

Overview:
Parametrised successor of the cakegame top. A single self-contained Simon-style memory game: each round appends a pseudo-random item to a stored sequence, plays the whole sequence back on the outputs, then checks the player's button presses in order against it. Button count, maximum sequence length, display and timeout periods, and the number of lives are all parameters. It sits directly under the board top and takes debounced buttons and a start level.

Parameters:
N_BUTTONS, 7, number of buttons and display lamps; range 2..16.
SEQ_LEN, 16, rounds needed to win, which is also the sequence memory depth; range 1..64.
SHOW_CYCLES, 1000, clock cycles each item is lit, and also the dark gap after each item.
TIMEOUT_CYCLES, 5000, clock cycles allowed for each press.
LIVES, 3, errors allowed per game; range 1..7.
POINTS_W, 4, width of the score counter.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
jogar  in  1  start request; sampled in IDLE, WIN and LOSE.
dificuldade  in  1  sampled on start; 1 halves SHOW_CYCLES and TIMEOUT_CYCLES (integer division, floor).
botoes  in  N_BUTTONS  debounced buttons, active high.
jogadas  out  N_BUTTONS  lamps: one-hot item in SHOW_ON, a copy of botoes in WAIT_PLAY, otherwise 0.
estado  out  4  current state code.
pontuacao  out  POINTS_W  completed rounds; saturates at all-ones.
vidas  out  3  remaining lives.
pronto  out  1  high in WIN or LOSE.
ganhou  out  1  high in WIN only.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; clock and reset ports are named clock and reset.
- Reset state: state IDLE; all outputs 0 except vidas=0. Sequence memory contents are don't-care. The LFSR is loaded with 16'hACE1.
- Reset mid-game: returns to IDLE on the next edge, whatever the current state.
- Random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, stepping every cycle.
  - Candidate item v = low IDX_W bits of the LFSR, where IDX_W = clog2(N_BUTTONS).
  - Stored item = v if v<N, else v-N.
- Press detection: prev_botoes is registered every cycle. A press is a cycle where botoes is nonzero and prev_botoes==0.
  - Valid press: exactly one bit set. Its index is compared with seq[pos].
  - A press with two or more bits set counts as wrong.
- State codes and transitions:
  - 0 IDLE: on jogar go to INIT.
  - 1 INIT: round=0, pontuacao=0, vidas=LIVES, latch dificuldade. Go to APPEND.
  - 2 APPEND: seq[round] <= item; round <= round+1; pos=0. Go to SHOW_ON.
  - 3 SHOW_ON: lamp seq[pos] lit for show period P. Then go to SHOW_OFF.
  - 4 SHOW_OFF: dark for P. Then pos+1; if pos+1<round go to SHOW_ON, else pos=0, clear timer, go to WAIT_PLAY.
  - 5 WAIT_PLAY:
    - Correct press: pos+1 and timer cleared; if pos+1==round go to ROUND_OK.
    - Wrong press: go to WRONG.
    - Timer reaches T-1 with no press: go to WRONG.
    - Press and expiry in the same cycle: the press wins.
  - 8 ROUND_OK: pontuacao+1 (saturating). If round==SEQ_LEN go to WIN, else go to APPEND.
  - 9 WRONG: vidas-1. If the result is 0 go to LOSE; else pos=0 and go to SHOW_ON, replaying the same round with no new item.
  - 10 WIN / 11 LOSE: hold all outputs; jogar goes to INIT.
  - Codes 6, 7, 12-15 are unused and decode to IDLE.
- Latency: start-to-first-lamp is 3 cycles (IDLE→INIT→APPEND→SHOW_ON). A held jogar in WIN/LOSE restarts immediately.
- Counters: show and timeout counters are wide enough for the largest value and count 0..P-1 and 0..T-1. Each is cleared on entry to its state.

Optional Feature:
Macro CAKEGAME_PAUSE_EN adds input pausar (1 bit).
- While pausar=1 in SHOW_ON, SHOW_OFF or WAIT_PLAY: state, counters and pos are frozen; presses are ignored; jogadas is forced to 0. prev_botoes still updates.
- When pausar falls, operation resumes at the frozen count.
- Without the macro the port does not exist and no pause logic is built.

Test Plan:
Parameters for all scenarios: N=4, SEQ_LEN=3, SHOW=4, TIMEOUT=8, LIVES=2.
- Reset then jogar=1: estado 0→1→2→3; vidas=2; a one-hot lamp is held 4 cycles, then 4 dark cycles, then estado=5.
- Press the correct button each round: pontuacao goes 1,2,3; estado reaches 10; pronto=1 and ganhou=1; a new jogar restarts with pontuacao=0.
- Wrong button in round 1: vidas=1; the same item is replayed (jogadas identical); a second wrong press gives estado=11, pronto=1, ganhou=0.
- No press for 8 cycles in WAIT_PLAY: goes to WRONG and vidas decrements. Two buttons pressed together counts as wrong. A button held from SHOW_OFF into WAIT_PLAY produces no press.
- dificuldade=1: lamp lit 2 cycles and timeout after 4 cycles. Reset asserted during SHOW_ON: next cycle estado=0, all outputs 0.
- With CAKEGAME_PAUSE_EN: pausar=1 for 10 cycles during SHOW_ON freezes estado and the counter and holds jogadas=0; the remaining lit cycles complete after release.

Source files
------------

// File: rtl/cakegame_multi.sv
// cakegame_multi: parametrised Simon-style memory game.
// Each round appends an LFSR-derived item to the stored sequence, plays the
// whole sequence on the lamps, then checks the player's presses in order.
// Optional feature: define CAKEGAME_PAUSE_EN to add the pausar input, which
// freezes the show/wait phases and darkens the lamps while high.
module cakegame_multi #(
  parameter int N_BUTTONS      = 7,
  parameter int SEQ_LEN        = 16,
  parameter int SHOW_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int LIVES          = 3,
  parameter int POINTS_W       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 jogar,
  input  logic                 dificuldade,
  input  logic [N_BUTTONS-1:0] botoes,
`ifdef CAKEGAME_PAUSE_EN
  input  logic                 pausar,
`endif
  output logic [N_BUTTONS-1:0] jogadas,
  output logic [3:0]           estado,
  output logic [POINTS_W-1:0]  pontuacao,
  output logic [2:0]           vidas,
  output logic                 pronto,
  output logic                 ganhou
);

  localparam int IDX_W  = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
  localparam int RND_W  = $clog2(SEQ_LEN + 1);
  localparam int ADDR_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int MEM_D  = 1 << ADDR_W;
  localparam int TMAX   = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);
  // Halved periods never drop below one cycle.
  localparam int SHOW_H = (SHOW_CYCLES / 2 > 0) ? SHOW_CYCLES / 2 : 1;
  localparam int TO_H   = (TIMEOUT_CYCLES / 2 > 0) ? TIMEOUT_CYCLES / 2 : 1;
  localparam logic [TMR_W-1:0] SHOW_LAST_F = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] SHOW_LAST_H = TMR_W'(SHOW_H - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST_F = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST_H = TMR_W'(TO_H - 1);
  localparam logic [N_BUTTONS-1:0] ONE_LAMP = {{(N_BUTTONS-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_APPEND    = 4'd2,
    S_SHOW_ON   = 4'd3,
    S_SHOW_OFF  = 4'd4,
    S_WAIT_PLAY = 4'd5,
    S_ROUND_OK  = 4'd8,
    S_WRONG     = 4'd9,
    S_WIN       = 4'd10,
    S_LOSE      = 4'd11
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [N_BUTTONS-1:0]  prev_q, prev_d;
  logic [RND_W-1:0]      round_q, round_d;
  logic [RND_W-1:0]      pos_q, pos_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  diff_q, diff_d;
  logic [POINTS_W-1:0]   pontos_q, pontos_d;
  logic [2:0]            vidas_q, vidas_d;
  logic [N_BUTTONS-1:0]  jogadas_q, jogadas_d;
  logic                  pronto_q, pronto_d;
  logic                  ganhou_q, ganhou_d;
  logic [IDX_W-1:0]      seq_q [MEM_D];

  logic [IDX_W-1:0]      cand_s, item_s, press_idx_s, show_item_s;
  logic [ADDR_W-1:0]     wr_addr_s, pos_addr_s, show_addr_s;
  logic [RND_W-1:0]      pos_next_s;
  logic [TMR_W-1:0]      show_last_s, wait_last_s;
  logic                  press_s, single_s, hit_s, seq_we_s;
  logic                  hold_s, hold_next_s;

  // Candidate item folds out-of-range LFSR values back into 0..N-1.
  assign cand_s      = lfsr_q[IDX_W-1:0];
  assign item_s      = (int'(cand_s) < N_BUTTONS) ? cand_s : IDX_W'(int'(cand_s) - N_BUTTONS);
  assign wr_addr_s   = ADDR_W'(round_q);
  assign pos_addr_s  = ADDR_W'(pos_q);
  assign pos_next_s  = pos_q + RND_W'(1);
  assign show_last_s = diff_q ? SHOW_LAST_H : SHOW_LAST_F;
  assign wait_last_s = diff_q ? WAIT_LAST_H : WAIT_LAST_F;
  assign press_s     = (botoes != '0) && (prev_q == '0);
  assign single_s    = (botoes != '0) && ((botoes & (botoes - ONE_LAMP)) == '0);
  assign hit_s       = single_s && (press_idx_s == seq_q[pos_addr_s]);

`ifdef CAKEGAME_PAUSE_EN
  assign hold_s      = pausar && ((state_q == S_SHOW_ON) || (state_q == S_SHOW_OFF) ||
                                  (state_q == S_WAIT_PLAY));
  assign hold_next_s = pausar && ((state_d == S_SHOW_ON) || (state_d == S_SHOW_OFF) ||
                                  (state_d == S_WAIT_PLAY));
`else
  assign hold_s      = 1'b0;
  assign hold_next_s = 1'b0;
`endif

  // Encode the index of the pressed button (meaningful only for a single press).
  always_comb begin
    press_idx_s = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      press_idx_s = botoes[i] ? IDX_W'(i) : press_idx_s;
    end
  end

  // Game sequencing: next state, counters, score, lives and LFSR step.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    pos_d    = pos_q;
    timer_d  = timer_q;
    diff_d   = diff_q;
    pontos_d = pontos_q;
    vidas_d  = vidas_q;
    seq_we_s = 1'b0;
    prev_d   = botoes;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      S_IDLE: begin
        if (jogar) state_d = S_INIT;
        else       state_d = S_IDLE;
      end
      S_INIT: begin
        round_d  = '0;
        pontos_d = '0;
        vidas_d  = 3'(LIVES);
        diff_d   = dificuldade;
        state_d  = S_APPEND;
      end
      S_APPEND: begin
        seq_we_s = 1'b1;
        round_d  = round_q + RND_W'(1);
        pos_d    = '0;
        timer_d  = '0;
        state_d  = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (hold_s) begin
          timer_d = timer_q;
        end else if (timer_q == show_last_s) begin
          timer_d = '0;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_SHOW_OFF: begin
        if (hold_s) begin
          timer_d = timer_q;
        end else if (timer_q == show_last_s) begin
          timer_d = '0;
          if (pos_next_s < round_q) begin
            pos_d   = pos_next_s;
            state_d = S_SHOW_ON;
          end else begin
            pos_d   = '0;
            state_d = S_WAIT_PLAY;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT_PLAY: begin
        // A press in the expiry cycle takes precedence over the timeout.
        if (hold_s) begin
          timer_d = timer_q;
        end else if (press_s) begin
          if (hit_s) begin
            pos_d   = pos_next_s;
            timer_d = '0;
            if (pos_next_s == round_q) state_d = S_ROUND_OK;
            else                       state_d = S_WAIT_PLAY;
          end else begin
            state_d = S_WRONG;
          end
        end else if (timer_q == wait_last_s) begin
          state_d = S_WRONG;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ROUND_OK: begin
        pontos_d = (pontos_q == {POINTS_W{1'b1}}) ? pontos_q : pontos_q + POINTS_W'(1);
        state_d  = (round_q == RND_W'(SEQ_LEN)) ? S_WIN : S_APPEND;
      end
      S_WRONG: begin
        vidas_d = vidas_q - 3'd1;
        if (vidas_q == 3'd1) begin
          state_d = S_LOSE;
        end else begin
          pos_d   = '0;
          timer_d = '0;
          state_d = S_SHOW_ON;
        end
      end
      S_WIN, S_LOSE: begin
        if (jogar) state_d = S_INIT;
        else       state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next lamp/flag values follow the next state so the outputs can be flopped.
  // The item being appended this cycle is forwarded to the lamp directly.
  always_comb begin
    show_addr_s = ADDR_W'(pos_d);
    show_item_s = (seq_we_s && (wr_addr_s == show_addr_s)) ? item_s : seq_q[show_addr_s];
    if (hold_next_s) begin
      jogadas_d = '0;
    end else if (state_d == S_SHOW_ON) begin
      jogadas_d = ONE_LAMP << show_item_s;
    end else if (state_d == S_WAIT_PLAY) begin
      jogadas_d = botoes;
    end else begin
      jogadas_d = '0;
    end
    pronto_d = (state_d == S_WIN) || (state_d == S_LOSE);
    ganhou_d = (state_d == S_WIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 16'hACE1;
      prev_q    <= '0;
      round_q   <= '0;
      pos_q     <= '0;
      timer_q   <= '0;
      diff_q    <= 1'b0;
      pontos_q  <= '0;
      vidas_q   <= 3'd0;
      jogadas_q <= '0;
      pronto_q  <= 1'b0;
      ganhou_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      prev_q    <= prev_d;
      round_q   <= round_d;
      pos_q     <= pos_d;
      timer_q   <= timer_d;
      diff_q    <= diff_d;
      pontos_q  <= pontos_d;
      vidas_q   <= vidas_d;
      jogadas_q <= jogadas_d;
      pronto_q  <= pronto_d;
      ganhou_q  <= ganhou_d;
    end
  end

  // Sequence memory; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (seq_we_s && !reset) seq_q[wr_addr_s] <= item_s;
  end

  assign jogadas   = jogadas_q;
  assign estado    = state_q;
  assign pontuacao = pontos_q;
  assign vidas     = vidas_q;
  assign pronto    = pronto_q;
  assign ganhou    = ganhou_q;

endmodule
